// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues one outstanding memory request at a time and
// presents the returned word to decode, with a one-entry hold buffer for decode stalls.
module instruction_fetch_stage #(
  parameter logic [31:0] NOP  = 32'h00000013,
  parameter logic        HIGH = 1'b1,
  parameter logic        LOW  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        PC_VALID,
  input  logic        CLEAR_INSTRUCTION_FETCH_STAGE,
  input  logic        STALL_INSTRUCTION_FETCH_STAGE,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        STALL_PROGRAME_COUNTER_STAGE,
  output logic [31:0] PC_FETCH,
  output logic [31:0] INSTRUCTION,
  output logic        INSTRUCTION_VALID,
  output logic [1:0]  DEBUG_STATE,
  output logic        DEBUG_HOLD_VALID
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  logic clear;
  logic stall;
  logic rsp_in_wait;
  logic consume;
  logic may_request;
  logic accept;

  assign clear = CLEAR_INSTRUCTION_FETCH_STAGE;
  assign stall = STALL_INSTRUCTION_FETCH_STAGE;

  // Handshake: a request transfers in any cycle where IMEM_REQ and IMEM_READY are
  // both high (REQ does not wait on READY); IMEM_RVALID is a single-cycle pulse
  // carrying the response to the one outstanding request and is never back-pressured.
  assign rsp_in_wait = (state == S_WAIT) && IMEM_RVALID && !clear;
  assign consume     = rsp_in_wait && !stall;
  assign may_request = (state == S_IDLE) || consume;

  assign IMEM_REQ  = PC_VALID && !clear && !RST && !hold_valid && may_request;
  assign IMEM_ADDR = PC;
  assign accept    = IMEM_REQ && IMEM_READY;

  assign STALL_PROGRAME_COUNTER_STAGE = RST || !(accept || clear);

  assign DEBUG_STATE      = state;
  assign DEBUG_HOLD_VALID = hold_valid;

  // A clear in DRAIN without a response keeps waiting for the abandoned reply;
  // the reply itself always returns the FSM to IDLE so it can never strand.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (clear) state_next = IMEM_RVALID ? S_IDLE : S_DRAIN;
        else if (IMEM_RVALID) state_next = accept ? S_WAIT : S_IDLE;
      end
      S_DRAIN: begin
        if (IMEM_RVALID) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= S_IDLE;
      req_pc            <= '0;
      hold_valid        <= LOW;
      hold_pc           <= '0;
      hold_instr        <= '0;
      INSTRUCTION_VALID <= LOW;
      INSTRUCTION       <= NOP;
      PC_FETCH          <= '0;
    end else begin
      state <= state_next;
      if (accept) req_pc <= PC;
      if (rsp_in_wait && stall) begin
        hold_pc    <= req_pc;
        hold_instr <= IMEM_RDATA;
      end
      // Buffer drain and a direct response cannot coincide: no request is
      // issued while the buffer is full.
      if (clear) begin
        INSTRUCTION_VALID <= LOW;
        INSTRUCTION       <= NOP;
        hold_valid        <= LOW;
      end else if (stall) begin
        if (rsp_in_wait) hold_valid <= HIGH;
      end else if (hold_valid) begin
        PC_FETCH          <= hold_pc;
        INSTRUCTION       <= hold_instr;
        INSTRUCTION_VALID <= HIGH;
        hold_valid        <= LOW;
      end else if (consume) begin
        PC_FETCH          <= req_pc;
        INSTRUCTION       <= IMEM_RDATA;
        INSTRUCTION_VALID <= HIGH;
      end else begin
        INSTRUCTION_VALID <= LOW;
        INSTRUCTION       <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed cycle table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOPV     = 32'h00000013;
  localparam logic [1:0]  ST_IDLE  = 2'b00;
  localparam logic [1:0]  ST_WAIT  = 2'b01;
  localparam logic [1:0]  ST_DRAIN = 2'b10;
  localparam int          N_VEC    = 23;
  localparam int          N_RAND   = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        clear;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_pc;
  logic [31:0] pc_fetch;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [1:0]  dbg_state;
  logic        dbg_hold;

  instruction_fetch_stage dut (
    .CLK                           (clk),
    .RST                           (rst),
    .PC                            (pc),
    .PC_VALID                      (pc_valid),
    .CLEAR_INSTRUCTION_FETCH_STAGE (clear),
    .STALL_INSTRUCTION_FETCH_STAGE (stall),
    .IMEM_REQ                      (imem_req),
    .IMEM_ADDR                     (imem_addr),
    .IMEM_READY                    (imem_ready),
    .IMEM_RVALID                   (imem_rvalid),
    .IMEM_RDATA                    (imem_rdata),
    .STALL_PROGRAME_COUNTER_STAGE  (stall_pc),
    .PC_FETCH                      (pc_fetch),
    .INSTRUCTION                   (instruction),
    .INSTRUCTION_VALID             (instruction_valid),
    .DEBUG_STATE                   (dbg_state),
    .DEBUG_HOLD_VALID              (dbg_hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic cyc(input logic r, input logic pv, input logic [31:0] p, input logic c,
                     input logic s, input logic rd, input logic rv, input logic [31:0] dat);
    @(negedge clk);
    rst = r; pc_valid = pv; pc = p; clear = c; stall = s;
    imem_ready = rd; imem_rvalid = rv; imem_rdata = dat;
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic iv, input logic [31:0] ins,
                          input logic [31:0] pcf, input logic [1:0] st, input logic hv);
    chk({tag, ".ivalid"}, instruction_valid, iv);
    chk({tag, ".instr"},  instruction, ins);
    chk({tag, ".pcf"},    pc_fetch, pcf);
    chk({tag, ".state"},  dbg_state, st);
    chk({tag, ".hold"},   dbg_hold, hv);
  endtask

  typedef struct {
    logic        pcv;
    logic [31:0] pc;
    logic        clr, stl, rdy, rv;
    logic [31:0] rd;
    logic        req, spc, iv;
    logic [31:0] instr, pcf;
    logic [1:0]  st;
    logic        hold;
  } vec_t;

  function automatic vec_t mk(logic pcv, logic [31:0] p, logic clr, logic stl, logic rdy,
                              logic rv, logic [31:0] rd, logic req, logic spc, logic iv,
                              logic [31:0] ins, logic [31:0] pcf, logic [1:0] st, logic hold);
    vec_t v;
    v.pcv = pcv; v.pc = p; v.clr = clr; v.stl = stl; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.req = req; v.spc = spc; v.iv = iv; v.instr = ins; v.pcf = pcf; v.st = st; v.hold = hold;
    return v;
  endfunction

  // Reference model: outstanding requests as a queue, decode hold buffer as a queue.
  typedef struct { logic [31:0] pc; logic [31:0] data; } hb_t;
  logic [31:0] exp_q[$];
  hb_t         m_hold_q[$];
  bit          m_drop;
  logic        m_iv;
  logic [31:0] m_instr, m_pcf;

  task automatic model_reset();
    exp_q.delete(); m_hold_q.delete(); m_drop = 0;
    m_iv = 1'b0; m_instr = NOPV; m_pcf = 32'h0;
  endtask

  task automatic model_step(input logic pcv, input logic [31:0] p, input logic clr,
                            input logic stl, input logic rdy, input logic rv,
                            input logic [31:0] rd, input string tag);
    bit busy, rsp, direct, e_req, e_acc, e_spc;
    logic [1:0] e_st;
    hb_t h;
    busy   = exp_q.size() != 0;
    rsp    = busy && rv;
    direct = rsp && !m_drop && !clr && !stl;
    e_req  = pcv && !clr && (m_hold_q.size() == 0) && (!busy || direct);
    e_acc  = e_req && rdy;
    e_spc  = !(e_acc || clr);
    e_st   = !busy ? ST_IDLE : (m_drop ? ST_DRAIN : ST_WAIT);
    chk({tag, ".req"},  imem_req, e_req);
    chk({tag, ".spc"},  stall_pc, e_spc);
    chk({tag, ".addr"}, imem_addr, p);
    chk_regs(tag, m_iv, m_instr, m_pcf, e_st, m_hold_q.size() != 0);
    if (clr) begin
      m_iv = 1'b0; m_instr = NOPV; m_hold_q.delete();
    end else if (stl) begin
      if (rsp && !m_drop) begin
        h.pc = exp_q[0]; h.data = rd; m_hold_q.push_back(h);
      end
    end else if (m_hold_q.size() != 0) begin
      h = m_hold_q.pop_front();
      m_iv = 1'b1; m_instr = h.data; m_pcf = h.pc;
    end else if (direct) begin
      m_iv = 1'b1; m_instr = rd; m_pcf = exp_q[0];
    end else begin
      m_iv = 1'b0; m_instr = NOPV;
    end
    if (rsp) begin
      void'(exp_q.pop_front()); m_drop = 0;
    end else if (busy && clr) begin
      m_drop = 1;
    end
    if (e_acc) exp_q.push_back(p);
  endtask

  vec_t tbl[N_VEC];

  initial begin
    logic [31:0] D0, D4, D8, DB, BAD, D100, D108, STALE;
    bit          rsp_pend;
    int          rsp_cnt;
    logic [31:0] rsp_addr, cur_pc, rdat, tgt;
    logic        pv, c, s, rd, rvn, dut_acc;

    D0 = 32'h11110000; D4 = 32'h22220004; D8 = 32'h33330008; DB = 32'hDEADBEEF;
    BAD = 32'hBAD0BAD0; D100 = 32'h44440100; D108 = 32'h55550108; STALE = 32'h57A1E000;

    //             pcv pc       clr stl rdy rv rd      req spc iv instr  pcf       st        hold
    tbl[0]  = mk(1, 32'h000, 0, 0, 1, 0, 0,     1, 0, 0, NOPV, 32'h00,  ST_IDLE,  0);
    tbl[1]  = mk(1, 32'h004, 0, 0, 1, 1, D0,    1, 0, 0, NOPV, 32'h00,  ST_WAIT,  0);
    tbl[2]  = mk(1, 32'h008, 0, 0, 1, 1, D4,    1, 0, 1, D0,   32'h00,  ST_WAIT,  0);
    tbl[3]  = mk(0, 32'h00c, 0, 0, 1, 1, D8,    0, 1, 1, D4,   32'h04,  ST_WAIT,  0);
    tbl[4]  = mk(0, 32'h00c, 0, 0, 1, 0, 0,     0, 1, 1, D8,   32'h08,  ST_IDLE,  0);
    tbl[5]  = mk(1, 32'h010, 0, 0, 1, 0, 0,     1, 0, 0, NOPV, 32'h08,  ST_IDLE,  0);
    tbl[6]  = mk(1, 32'h014, 0, 1, 1, 1, DB,    0, 1, 0, NOPV, 32'h08,  ST_WAIT,  0);
    tbl[7]  = mk(1, 32'h014, 0, 1, 1, 0, 0,     0, 1, 0, NOPV, 32'h08,  ST_IDLE,  1);
    tbl[8]  = mk(1, 32'h014, 0, 0, 1, 0, 0,     0, 1, 0, NOPV, 32'h08,  ST_IDLE,  1);
    tbl[9]  = mk(1, 32'h014, 0, 0, 1, 0, 0,     1, 0, 1, DB,   32'h10,  ST_IDLE,  0);
    tbl[10] = mk(1, 32'h100, 1, 0, 1, 0, 0,     0, 0, 0, NOPV, 32'h10,  ST_WAIT,  0);
    tbl[11] = mk(1, 32'h100, 0, 0, 1, 0, 0,     0, 1, 0, NOPV, 32'h10,  ST_DRAIN, 0);
    tbl[12] = mk(1, 32'h100, 0, 0, 1, 0, 0,     0, 1, 0, NOPV, 32'h10,  ST_DRAIN, 0);
    tbl[13] = mk(1, 32'h100, 0, 0, 1, 1, BAD,   0, 1, 0, NOPV, 32'h10,  ST_DRAIN, 0);
    tbl[14] = mk(1, 32'h100, 0, 0, 1, 0, 0,     1, 0, 0, NOPV, 32'h10,  ST_IDLE,  0);
    tbl[15] = mk(1, 32'h104, 0, 0, 1, 1, D100,  1, 0, 0, NOPV, 32'h10,  ST_WAIT,  0);
    tbl[16] = mk(1, 32'h108, 0, 1, 1, 0, 0,     0, 1, 1, D100, 32'h100, ST_WAIT,  0);
    tbl[17] = mk(1, 32'h108, 1, 1, 1, 0, 0,     0, 0, 1, D100, 32'h100, ST_WAIT,  0);
    tbl[18] = mk(1, 32'h108, 0, 0, 1, 1, BAD,   0, 1, 0, NOPV, 32'h100, ST_DRAIN, 0);
    tbl[19] = mk(1, 32'h108, 0, 0, 1, 0, 0,     1, 0, 0, NOPV, 32'h100, ST_IDLE,  0);
    tbl[20] = mk(1, 32'h10c, 0, 1, 1, 1, D108,  0, 1, 0, NOPV, 32'h100, ST_WAIT,  0);
    tbl[21] = mk(1, 32'h10c, 1, 1, 1, 0, 0,     0, 0, 0, NOPV, 32'h100, ST_IDLE,  1);
    tbl[22] = mk(0, 32'h10c, 0, 0, 1, 0, 0,     0, 1, 0, NOPV, 32'h100, ST_IDLE,  0);

    // Reset: request suppressed and PC held while RST is high.
    cyc(1, 1, 32'h0, 0, 0, 1, 0, 0);
    chk("rst.req", imem_req, 1'b0);
    chk("rst.spc", stall_pc, 1'b1);
    cyc(1, 1, 32'h0, 1, 0, 1, 0, 0);
    chk("rst_clr.spc", stall_pc, 1'b1);
    cyc(0, 0, 32'h0, 0, 0, 1, 0, 0);
    chk_regs("rst", 1'b0, NOPV, 32'h0, ST_IDLE, 1'b0);

    for (int i = 0; i < N_VEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(0, tbl[i].pcv, tbl[i].pc, tbl[i].clr, tbl[i].stl, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      chk({tag, ".req"},  imem_req, tbl[i].req);
      chk({tag, ".spc"},  stall_pc, tbl[i].spc);
      chk({tag, ".addr"}, imem_addr, tbl[i].pc);
      chk_regs(tag, tbl[i].iv, tbl[i].instr, tbl[i].pcf, tbl[i].st, tbl[i].hold);
    end

    // Memory not ready for 4 cycles: PC held, address stable, nothing presented.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'h200, 0, 0, 0, 0, 0);
      chk($sformatf("nrdy%0d.req", i), imem_req, 1'b1);
      chk($sformatf("nrdy%0d.spc", i), stall_pc, 1'b1);
      chk($sformatf("nrdy%0d.addr", i), imem_addr, 32'h200);
      chk($sformatf("nrdy%0d.ivalid", i), instruction_valid, 1'b0);
    end
    cyc(0, 1, 32'h200, 0, 0, 1, 0, 0);
    chk("nrdy_go.spc", stall_pc, 1'b0);

    // Reset while a request is outstanding, then a stale response arrives.
    cyc(1, 1, 32'h204, 0, 0, 1, 0, 0);
    chk("rstw.state", dbg_state, ST_WAIT);
    chk("rstw.req", imem_req, 1'b0);
    chk("rstw.spc", stall_pc, 1'b1);
    cyc(0, 0, 32'h204, 0, 0, 1, 1, STALE);
    chk_regs("rstw1", 1'b0, NOPV, 32'h0, ST_IDLE, 1'b0);
    cyc(0, 0, 32'h204, 0, 0, 1, 0, 0);
    chk_regs("rstw2", 1'b0, NOPV, 32'h0, ST_IDLE, 1'b0);

    // Random traffic with a latency-randomising memory responder.
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
    model_reset();
    rsp_pend = 0; rsp_cnt = 0; rsp_addr = 0; cur_pc = 32'h1000;
    for (int i = 0; i < N_RAND; i++) begin
      pv   = ($urandom_range(0, 9) < 8);
      c    = ($urandom_range(0, 99) < 8);
      s    = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 9) < 7);
      rvn  = rsp_pend && (rsp_cnt == 0);
      rdat = rvn ? {rsp_addr[15:0], ~rsp_addr[15:0]} : $urandom;
      cyc(0, pv, cur_pc, c, s, rd, rvn, rdat);
      model_step(pv, cur_pc, c, s, rd, rvn, rdat, $sformatf("rnd%0d", i));
      dut_acc = imem_req && imem_ready;
      if (rvn) rsp_pend = 0;
      else if (rsp_pend) rsp_cnt--;
      if (dut_acc) begin
        rsp_pend = 1; rsp_cnt = $urandom_range(0, 2); rsp_addr = cur_pc;
      end
      if (c) begin
        tgt = $urandom;
        cur_pc = {tgt[31:2], 2'b00};
      end else if (dut_acc) begin
        cur_pc = cur_pc + 32'd4;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
